// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: no owner, or one requester owns the FIFO write port.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Largest supported burst; the beat counter is sized to hold it.
  localparam int MAX_BURST_LIMIT = 16;
  localparam int BURST_CNT_W     = $clog2(MAX_BURST_LIMIT + 1);

endpackage : fifo_arb_pkg

// File: rtl/rr_picker.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win_onehot,
  output logic [PTR_W-1:0] win_idx,
  output logic             win_valid
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    for (int off = 0; off < N; off++) begin
      logic [PTR_W-1:0] pos;
      pos = PTR_W'((int'(ptr) + off) % N);
      if (!win_valid && req[pos]) begin
        win_valid       = 1'b1;
        win_idx         = pos;
        win_onehot[pos] = 1'b1;
      end
    end
  end

endmodule : rr_picker

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter feeding a single FIFO write port.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       wr_clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       full,
  output logic                       write_en,
  output logic [WIDTH-1:0]           write_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [BURST_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [WIDTH-1:0]   data_arr [NUM_REQ];
  logic               owner_req;
  logic               last_beat;
  logic [ID_W-1:0]    next_ptr;
  logic [ID_W-1:0]    pick_ptr;
  logic [NUM_REQ-1:0] win_onehot;
  logic [ID_W-1:0]    win_idx;
  logic               win_valid;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  assign owner_req = req[grant_id_q];
  assign last_beat = (beat_cnt_q == BURST_CNT_W'(MAX_BURST - 1));
  assign next_ptr  = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
  // While owning, arbitrate from the slot after the owner so a release can
  // hand over in the same cycle and the old owner ranks last.
  assign pick_ptr  = (state_q == GRANT) ? next_ptr : rr_ptr_q;

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_picker (
    .req        (req),
    .ptr        (pick_ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  // Write port and handshakes follow the registered owner combinationally.
  assign busy       = (state_q == GRANT);
  assign write_en   = busy & owner_req & ~full & ~reset;
  assign write_data = busy ? data_arr[grant_id_q] : '0;
  assign req_ready  = {NUM_REQ{write_en}} & grant_q;
  assign grant      = grant_q;
  assign grant_id   = grant_id_q;

  // Next-state: grant on request, count beats, release and hand over.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d    = GRANT;
          grant_d    = win_onehot;
          grant_id_d = win_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        // A full FIFO freezes the burst in place, however long it lasts.
        if (!full) begin
          if (owner_req) beat_cnt_d = beat_cnt_q + 1'b1;
          if (!owner_req || last_beat) begin
            rr_ptr_d   = next_ptr;
            beat_cnt_d = '0;
            if (win_valid) begin
              grant_d    = win_onehot;
              grant_id_d = win_idx;
            end else begin
              state_d    = IDLE;
              grant_d    = '0;
              grant_id_d = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset abandons any burst.
  always_ff @(posedge wr_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule : fifo_write_arbiter

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with default parameters.
module tb_fifo_write_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic                       wr_clk = 1'b0;
  logic                       reset;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*WIDTH-1:0]   req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       full;
  logic                       write_en;
  logic [WIDTH-1:0]           write_data;
  logic [NUM_REQ-1:0]         grant;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic                       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt;

  fifo_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wr_clk     (wr_clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .full       (full),
    .write_en   (write_en),
    .write_data (write_data),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wr_clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // A cycle in which requester o owns the port and its beat is accepted.
  task automatic expect_beat(input string tag, input int o);
    chk({tag, "_grant"}, 32'(grant), 32'(1) << o);
    chk({tag, "_id"}, 32'(grant_id), 32'(o));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_we"}, 32'(write_en), 32'd1);
    chk({tag, "_data"}, 32'(write_data), 32'hA0 + 32'(o));
    chk({tag, "_ready"}, 32'(req_ready), 32'(1) << o);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Invariants sampled every cycle, midway between active edges.
  always @(negedge wr_clk) begin
    n_checks++;
    assert ($onehot0(grant)) else begin
      n_fail++;
      $error("FAIL inv_onehot: observed %b expected one-hot or zero", grant);
    end
    n_checks++;
    assert (!(write_en && full)) else begin
      n_fail++;
      $error("FAIL inv_full: observed write_en=%b full=%b expected no write", write_en, full);
    end
    n_checks++;
    assert (req_ready === ({NUM_REQ{write_en}} & grant)) else begin
      n_fail++;
      $error("FAIL inv_ready: observed %b expected %b", req_ready, {NUM_REQ{write_en}} & grant);
    end
  end

  initial begin
    reset    = 1'b1;
    full     = 1'b0;
    req      = '0;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    step();
    step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(write_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;

    // Single requester: one-cycle grant latency, 4 beats, seamless re-grant.
    req = 4'b0001;
    settle();
    chk("s1_idle_we", 32'(write_en), 32'd0);
    chk("s1_idle_grant", 32'(grant), 32'd0);
    step();
    for (int b = 0; b < MAX_BURST; b++) begin
      expect_beat("s1_burst", 0);
      step();
    end
    expect_beat("s1_regrant", 0);
    req = 4'b0000;
    settle();
    chk("s1_drop_we", 32'(write_en), 32'd0);
    chk("s1_drop_grant", 32'(grant), 32'b0001);
    step();
    chk("s1_idle_again_grant", 32'(grant), 32'd0);
    chk("s1_idle_again_busy", 32'(busy), 32'd0);

    // All requesting: order 0,1,2,3,0 with 4 beats each and no gaps.
    do_reset();
    req = 4'b1111;
    step();
    en_cnt = 0;
    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < MAX_BURST; b++) begin
        expect_beat("s2_rr", r % NUM_REQ);
        if (r < 4 && write_en) en_cnt++;
        step();
      end
    end
    chk("s2_contig16", 32'(en_cnt), 32'd16);

    // Backpressure: owner 2 stalls for 5 full cycles, then finishes.
    do_reset();
    req = 4'b0100;
    step();
    expect_beat("s3_beat1", 2);
    step();
    req = 4'b0101;
    settle();
    expect_beat("s3_beat2", 2);
    step();
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("s3_full_we", 32'(write_en), 32'd0);
      chk("s3_full_grant", 32'(grant), 32'b0100);
      chk("s3_full_ready", 32'(req_ready), 32'd0);
      step();
    end
    full = 1'b0;
    settle();
    expect_beat("s3_beat3", 2);
    step();
    expect_beat("s3_beat4", 2);
    step();
    expect_beat("s3_handover", 0);

    // Early release: owner 1 drops after one beat; pointer moves to 2.
    do_reset();
    req = 4'b0010;
    step();
    expect_beat("s4_beat1", 1);
    step();
    req = 4'b1001;
    settle();
    chk("s4_drop_we", 32'(write_en), 32'd0);
    chk("s4_drop_grant", 32'(grant), 32'b0010);
    step();
    expect_beat("s4_next", 3);

    // Reset mid-burst: write blocked at once, pointer back to 0.
    reset = 1'b1;
    settle();
    chk("s5_rst_we", 32'(write_en), 32'd0);
    chk("s5_rst_ready", 32'(req_ready), 32'd0);
    step();
    chk("s5_after_grant", 32'(grant), 32'd0);
    chk("s5_after_id", 32'(grant_id), 32'd0);
    chk("s5_after_busy", 32'(busy), 32'd0);
    chk("s5_after_we", 32'(write_en), 32'd0);
    reset = 1'b0;
    settle();
    chk("s5_idle_we", 32'(write_en), 32'd0);
    step();
    expect_beat("s5_first", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_write_arbiter

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, data width; matches the FIFO write_data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..16).
REQ-004 SHALL have port wr_clk  input  1  the single clock; all logic is in the FIFO write domain.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*WIDTH  requester i's data in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  beat accepted from requester i this cycle.
REQ-009 SHALL have port full  input  1  FIFO full flag.
REQ-010 SHALL have port write_en  output  1  FIFO write strobe.
REQ-011 SHALL have port write_data  output  WIDTH  FIFO write data.
REQ-012 SHALL have port grant  output  NUM_REQ  one-hot current owner, registered.
REQ-013 SHALL have port grant_id  output  $clog2(NUM_REQ)  index of the owner, 0 when idle.
REQ-014 SHALL have port busy  output  1  high in the GRANT state.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and GRANT; grant is all-zero in IDLE and exactly one-hot in GRANT.
REQ-016 SHALL, in IDLE with any req bit high, select the first set bit at or after rr_ptr, wrapping modulo NUM_REQ, and enter GRANT with that owner at the next edge (request-to-grant latency 1 cycle).
REQ-017 SHALL, in GRANT, combinationally drive write_en = req[owner] & !full & !reset and write_data = req_data slice of owner.
REQ-018 SHALL drive req_ready[i] = write_en & grant[i]; a beat transfers only when req_ready is high.
REQ-019 SHALL keep a beat counter, cleared on grant; it increments on each accepted beat.
REQ-020 SHALL hold grant, counter and state unchanged while full is high, with no timeout.
REQ-021 SHALL release the grant on the cycle where the MAX_BURST-th beat is accepted, or on any GRANT cycle with req[owner] low.
REQ-022 SHALL, on release, set rr_ptr = (owner+1) mod NUM_REQ and rearbitrate in the same cycle from that pointer; a winner gets GRANT at the next edge with no bubble, otherwise the FSM enters IDLE.
REQ-023 SHALL let the released requester win again only if no other req bit is high.
REQ-024 SHALL ignore req bits and req_data of non-owners; their req_ready is 0.
REQ-025 SHALL never assert write_en while full is high or in IDLE.

Reset
REQ-026 SHALL, at a wr_clk edge with reset high, force IDLE, grant=0, grant_id=0, busy=0, rr_ptr=0, and beat counter=0.
REQ-027 SHALL hold write_en and req_ready at 0 during any cycle reset is high, including mid-burst; an interrupted burst is not resumed.

Structure
REQ-028 SHALL take the state enum (IDLE, GRANT) and a MAX_BURST counter-width constant from shared package fifo_arb_pkg.
REQ-029 SHALL place rotating-priority selection (req vector, pointer -> one-hot winner, valid) in combinational sub-module rr_picker, instantiated once.

Verification
REQ-030 Bench SHALL check: req=4'b0001 held, full=0, with defaults -> grant=0001 one cycle later, 4 beats, then a fresh grant to requester 0 with no bubble.
REQ-031 Bench SHALL check: req=4'b1111 held, full=0 -> grant order 0,1,2,3,0, each 4 beats, 16 contiguous write_en cycles per round.
REQ-032 Bench SHALL check: owner 2 after 2 beats, full=1 for 5 cycles -> write_en=0 and grant=0100 held, then the remaining 2 beats complete.
REQ-033 Bench SHALL check: owner 1 drops req after beat 1 while req[3]=1 -> grant=1000 the next cycle, and rr_ptr=2 is reflected.
REQ-034 Bench SHALL check: reset asserted mid-burst -> write_en=0 that cycle, all outputs zero after the edge, first grant after reset goes to the lowest-index requester.
REQ-035 Bench SHALL assert every cycle: grant is one-hot or zero, write_en implies !full, and req_ready equals write_en & grant.
